// File: rtl/echo_pkg.sv
// Shared definitions for the echo datapath: sample width and framer states.
package echo_pkg;

    localparam int P_NBITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } framer_state_t;

endpackage

// File: rtl/echo_sample_fifo.sv
// Small val/rdy FIFO with push-side accept; a push into a full FIFO is taken if a pop happens in the same cycle.
module echo_sample_fifo #(
    parameter int p_width = 11,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_val,
    input  logic [p_width-1:0] push_data,
    output logic               push_acc,
    output logic               pop_val,
    input  logic               pop_rdy,
    output logic [p_width-1:0] pop_data
);

    localparam int AW = $clog2(p_depth);

    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [p_width-1:0] r_mem [p_depth];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop    = pop_val && pop_rdy;
    assign push_acc = !w_full || w_pop;
    assign w_push   = push_val && push_acc;
    assign pop_val  = !w_empty;
    assign pop_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < p_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= push_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/echo_sample_deserializer.sv
// Serial-to-parallel input stage: synchronises a frame-synced MSB-first bit stream and buffers samples in a FIFO.
//
// state    | meaning
// ST_IDLE  | waiting for a strobe with frame sync high (MSB)
// ST_SHIFT | collecting bits until p_nbits have arrived
// ST_PUSH  | one cycle: offer the completed word to the FIFO
module echo_sample_deserializer
    import echo_pkg::*;
#(
    parameter int p_nbits = P_NBITS,
    parameter int p_depth = 4,
    parameter int p_cntw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ser_sclk,
    input  logic               ser_fs,
    input  logic               ser_data,
    output logic               send_val,
    input  logic               send_rdy,
    output logic [p_nbits-1:0] send_msg,
    output logic               overflow,
    output logic               frame_err,
    output logic [p_cntw-1:0]  drop_count
);

    localparam int CW = $clog2(p_nbits + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(p_nbits);

    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_fs_s1, r_fs_s2;
    logic r_data_s1, r_data_s2;
    logic w_strobe;

    framer_state_t      r_state, w_state_nxt;
    logic [p_nbits-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]      r_bitcnt, w_bitcnt_nxt;
    logic [CW-1:0]      w_bitcnt_inc;
    logic               w_push;
    logic               w_ferr_set;
    logic               w_push_acc;
    logic               w_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_fs_s1   <= 1'b0;
            r_fs_s2   <= 1'b0;
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= ser_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_fs_s1   <= ser_fs;
            r_fs_s2   <= r_fs_s1;
            r_data_s1 <= ser_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_strobe     = r_sclk_s2 && !r_sclk_s3;
    assign w_bitcnt_inc = r_bitcnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_push       = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe && r_fs_s2) begin
                    w_shift_nxt  = {{(p_nbits-1){1'b0}}, r_data_s2};
                    w_bitcnt_nxt = CW'(1);
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_strobe) begin
                    if (r_fs_s2) begin
                        // Frame sync mid-word: drop the partial word and restart on this MSB.
                        w_ferr_set   = 1'b1;
                        w_shift_nxt  = {{(p_nbits-1){1'b0}}, r_data_s2};
                        w_bitcnt_nxt = CW'(1);
                    end else begin
                        w_shift_nxt  = {r_shift[p_nbits-2:0], r_data_s2};
                        w_bitcnt_nxt = w_bitcnt_inc;
                        if (w_bitcnt_inc == LAST_BIT) begin
                            w_state_nxt = ST_PUSH;
                        end
                    end
                end
            end
            ST_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    echo_sample_fifo #(
        .p_width (p_nbits),
        .p_depth (p_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_val  (w_push),
        .push_data (r_shift),
        .push_acc  (w_push_acc),
        .pop_val   (send_val),
        .pop_rdy   (send_rdy),
        .pop_data  (send_msg)
    );

    assign w_drop = w_push && !w_push_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (w_ferr_set) begin
                frame_err <= 1'b1;
            end
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != {p_cntw{1'b1}}) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_echo_sample_deserializer.sv
// Directed bench for echo_sample_deserializer: vector table for single/back-to-back words plus overflow, framing and reset sequences.
module tb_echo_sample_deserializer;

    logic        clk;
    logic        reset;
    logic        ser_sclk;
    logic        ser_fs;
    logic        ser_data;
    logic        send_val;
    logic        send_rdy;
    logic [10:0] send_msg;
    logic        overflow;
    logic        frame_err;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] q_got [$];

    echo_sample_deserializer #(
        .p_nbits (11),
        .p_depth (4),
        .p_cntw  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_sclk   (ser_sclk),
        .ser_fs     (ser_fs),
        .ser_data   (ser_data),
        .send_val   (send_val),
        .send_rdy   (send_rdy),
        .send_msg   (send_msg),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 ns after posedge; a transfer is recorded at the negedge before the edge that pops it.
    always @(negedge clk) begin
        if (reset && send_val && send_rdy) q_got.push_back(send_msg);
    end

    typedef struct {
        logic [10:0] word;
        logic        lat;
        logic        exp_ovf;
        logic        exp_ferr;
        logic [7:0]  exp_drop;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_xfer(input string name, input logic [10:0] exp);
        n_checks++;
        if (q_got.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got no transfer expected 0x%0h", name, exp);
        end else begin
            logic [10:0] got;
            got = q_got.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic fs, input logic d);
        ser_sclk = 1'b0;
        ser_fs   = fs;
        ser_data = d;
        tick(4);
        ser_sclk = 1'b1;
        tick(4);
    endtask

    // Last bit is unrolled so the PUSH cycle (3 edges after sclk rises) can be probed.
    task automatic send_word(input logic [10:0] w, input logic pulse_rdy, input logic lat_chk);
        for (int i = 10; i >= 1; i--) send_bit(i == 10, w[i]);
        ser_sclk = 1'b0;
        ser_fs   = 1'b0;
        ser_data = w[0];
        tick(4);
        ser_sclk = 1'b1;
        tick(3);
        if (lat_chk) chk("latency_push_cycle_val", {31'd0, send_val}, 32'd0);
        if (pulse_rdy) send_rdy = 1'b1;
        tick(1);
        if (pulse_rdy) send_rdy = 1'b0;
        if (lat_chk) chk("latency_val_after_push", {31'd0, send_val}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        q_got.delete();
    endtask

    initial begin
        vec_t vecs [4];
        vecs[0] = '{word: 11'h5A3, lat: 1'b1, exp_ovf: 1'b0, exp_ferr: 1'b0, exp_drop: 8'd0};
        vecs[1] = '{word: 11'h001, lat: 1'b0, exp_ovf: 1'b0, exp_ferr: 1'b0, exp_drop: 8'd0};
        vecs[2] = '{word: 11'h7FF, lat: 1'b0, exp_ovf: 1'b0, exp_ferr: 1'b0, exp_drop: 8'd0};
        vecs[3] = '{word: 11'h400, lat: 1'b0, exp_ovf: 1'b0, exp_ferr: 1'b0, exp_drop: 8'd0};

        ser_sclk = 1'b0;
        ser_fs   = 1'b0;
        ser_data = 1'b0;
        send_rdy = 1'b0;
        reset    = 1'b0;
        tick(3);
        chk("reset_val", {31'd0, send_val}, 32'd0);
        chk("reset_msg", {21'd0, send_msg}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b1;
        tick(2);

        // Single word and back-to-back words with downstream always ready.
        send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].word, 1'b0, vecs[i].lat);
            tick(2);
            chk_xfer("vec_xfer", vecs[i].word);
            chk("vec_extra_xfers", q_got.size(), 32'd0);
            chk("vec_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            chk("vec_ferr", {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            chk("vec_drop", {24'd0, drop_count}, {24'd0, vecs[i].exp_drop});
        end

        // Overflow: six words into a four-deep FIFO with no pops.
        send_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_word(11'h100 + 11'(i), 1'b0, 1'b0);
            tick(1);
            if (i == 3) chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            if (i == 4) chk("drop_after_5", {24'd0, drop_count}, 32'd1);
        end
        chk("ovf_val", {31'd0, send_val}, 32'd1);
        chk("ovf_head", {21'd0, send_msg}, 32'h100);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop", {24'd0, drop_count}, 32'd2);
        chk("ovf_ferr", {31'd0, frame_err}, 32'd0);
        chk("ovf_no_xfer", q_got.size(), 32'd0);

        // Full FIFO with a pop in the PUSH cycle: new word must be accepted.
        send_word(11'h0F0, 1'b1, 1'b0);
        tick(1);
        chk("fullpop_drop", {24'd0, drop_count}, 32'd2);
        chk_xfer("fullpop_popped", 11'h100);
        chk("fullpop_head", {21'd0, send_msg}, 32'h101);

        send_rdy = 1'b1;
        tick(8);
        chk_xfer("drain_1", 11'h101);
        chk_xfer("drain_2", 11'h102);
        chk_xfer("drain_3", 11'h103);
        chk_xfer("drain_4", 11'h0F0);
        chk("drain_empty_q", q_got.size(), 32'd0);
        chk("drain_val", {31'd0, send_val}, 32'd0);

        // Framing error: five bits of a word, then frame sync restarts with 0x123.
        do_reset();
        chk("rst_clears_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_clears_drop", {24'd0, drop_count}, 32'd0);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        send_word(11'h123, 1'b0, 1'b0);
        tick(2);
        chk("ferr_flag", {31'd0, frame_err}, 32'd1);
        chk_xfer("ferr_xfer", 11'h123);
        chk("ferr_single_xfer", q_got.size(), 32'd0);
        chk("ferr_ovf", {31'd0, overflow}, 32'd0);

        // Mid-word reset with a word already buffered.
        send_rdy = 1'b0;
        send_word(11'h3C3, 1'b0, 1'b0);
        tick(1);
        chk("pre_rst_val", {31'd0, send_val}, 32'd1);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        reset = 1'b0;
        tick(2);
        chk("midrst_val", {31'd0, send_val}, 32'd0);
        chk("midrst_msg", {21'd0, send_msg}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        chk("midrst_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b1;
        send_rdy = 1'b1;
        tick(8);
        chk("post_rst_no_spurious", q_got.size(), 32'd0);
        send_word(11'h2AA, 1'b0, 1'b0);
        tick(2);
        chk_xfer("post_rst_xfer", 11'h2AA);
        chk("post_rst_single", q_got.size(), 32'd0);
        chk("post_rst_ferr", {31'd0, frame_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_sample_deserializer.md
# echo_sample_deserializer

Upstream input stage of the echo datapath. Receives 11-bit audio samples from an external frame-synchronised serial source, reassembles them MSB-first, and buffers them in a small FIFO. Its val/rdy output connects directly to the echo unit's `recv_*` port. It absorbs short downstream stalls and reports dropped samples when the FIFO overflows.

## Interface
- `p_nbits`, 11, sample width; must equal the echo unit's message width.
- `p_depth`, 4, FIFO entries; power of two, ≥ 2.
- `p_cntw`, 8, width of the drop counter.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ser_sclk`  in  1  serial bit clock, asynchronous to `clk`.
- `ser_fs`  in  1  frame sync, high during the MSB bit.
- `ser_data`  in  1  serial data, valid on rising `ser_sclk`.
- `send_val`  out  1  FIFO non-empty.
- `send_rdy`  in  1  downstream ready.
- `send_msg`  out  p_nbits  FIFO head sample.
- `overflow`  out  1  sticky; a completed sample was dropped.
- `frame_err`  out  1  sticky; `ser_fs` was seen mid-word.
- `drop_count`  out  p_cntw  saturating count of dropped samples.

## Operation
- **Synchronisers:** each of `ser_sclk`, `ser_fs` and `ser_data` passes through a 2-flop synchroniser. A third flop on synchronised sclk gives edge detect. Bit strobe = synchronised sclk rising edge, one `clk` cycle wide.
- **Framer FSM states:** IDLE, SHIFT, PUSH.
  - IDLE: on strobe with fs=1, load the data bit into the shift register MSB path, bitcnt=1, go to SHIFT. A strobe with fs=0 is ignored.
  - SHIFT: on strobe, shift the data bit in and increment bitcnt. When bitcnt reaches `p_nbits`, go to PUSH.
  - SHIFT, framing error: a strobe with fs=1 before bitcnt reaches `p_nbits` sets `frame_err`, discards the partial word, and restarts with this bit as MSB (bitcnt=1, stay in SHIFT).
  - PUSH: one cycle. Write the word if the FIFO accepts it, otherwise drop it. Return to IDLE unconditionally.
- **FIFO accept rule:** accept if not full, or if full and a pop occurs in the same cycle (`send_val && send_rdy`).
- **On drop:** set `overflow`, and increment `drop_count` saturating at all-ones.
- **FIFO read side:** `send_msg` is driven from storage at the read pointer. `send_val` = !empty. Pop when `send_val && send_rdy`.
- **Pointers:** wrap modulo `p_depth`. An extra MSB distinguishes full from empty.
- **Sticky flags:** `overflow`, `frame_err` and `drop_count` clear only on reset.

## Timing
- **Reset:** asserting reset at any time clears the FSM to IDLE, empties the FIFO and discards any partial word. Reset outputs: `send_val`=0, `send_msg`=0 (storage is reset), `overflow`=0, `frame_err`=0, `drop_count`=0.
- **Latency:** pin edge to strobe = 3 cycles. Last-bit strobe in cycle N → PUSH in N+1 → `send_val`=1 in N+2 (if FIFO was empty).
- **Input constraint:** `ser_sclk` high and low phases must each be ≥ 3 `clk` cycles, so no strobe can coincide with PUSH. Behaviour outside this constraint is unspecified.
- **Handshake:** `send_msg` is stable while `send_val`=1 and `send_rdy`=0. There is no combinational path from `send_rdy` to `send_val`.
- **Throughput:** sustained throughput is one sample per `p_nbits` sclk periods, which the echo unit matches.

## Structure
- **Shared package `echo_pkg`:** the `p_nbits` default constant and the framer state enum typedef (IDLE/SHIFT/PUSH).
- **Sub-module `echo_sample_fifo`:** parameterised by width and depth. Ports are push val/data/accept and val/rdy pop. It is reused later for the output side.
- **Top level contents:** synchronisers, framer FSM, flag/counter logic, and a line trace in the `vc_trace` style: shift state, then val/rdy/msg.

## Test plan
- **Single word:** send fs + 11 bits 0x5A3 with `send_rdy`=1. Expect exactly one transfer of `send_msg`=0x5A3, `send_val` high 2 cycles after the last strobe, and all flags 0.
- **Back-to-back:** send 0x001, 0x7FF, 0x400 with `send_rdy`=1. Expect three transfers in order with the same values.
- **Overflow:** hold `send_rdy`=0 and send 6 words. Expect the FIFO to hold the first 4, `overflow`=1 and `drop_count`=2. Then raise `send_rdy`: expect the first 4 words to drain in order and `send_val`=0.
- **Full + simultaneous pop:** with the FIFO full, pulse `send_rdy` in the PUSH cycle. Expect the word accepted and `drop_count` unchanged.
- **Framing error:** assert fs again at bit 5, then complete 11 bits of 0x123. Expect `frame_err`=1 and one transfer of 0x123 only.
- **Mid-word reset:** assert reset after 6 bits, release, then send 0x2AA. Expect no spurious output, then one transfer of 0x2AA, with all outputs at reset values during reset.
